xy_stimulus_seq: RTL and testbench

- Stimulus and response stage for one my_module-style instance (inputs x, y; output z; identified by id_num).
- Drives the x/y operand pair through all four input combinations and holds each for a programmable number of cycles.
- Samples the instance's z at the end of each hold and assembles a 4-bit truth vector per pass.
- Compares each vector against an expected table and reports mismatches. It sits directly upstream (x/y) and downstream (z) of the instance inside top.

---
 rtl/xy_seq_pkg.sv | 17 +
 rtl/xy_result_chk.sv | 40 ++++
 rtl/xy_stimulus_seq.sv | 137 +++++++++++++
 tb/tb_xy_stimulus_seq.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/xy_seq_pkg.sv
// xy_seq_pkg: shared types and constants for the
// x/y stimulus sequencer and its result checker.
package xy_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int COMBO_W = 2;

  localparam logic [3:0] EXP_AND = 4'b1000;
  localparam logic [3:0] EXP_OR  = 4'b1110;
  localparam logic [3:0] EXP_XOR = 4'b0110;

endpackage

// File: rtl/xy_result_chk.sv
// xy_result_chk: registers each finished truth vector,
// flags mismatches and keeps a saturating error count.
module xy_result_chk
  import xy_seq_pkg::*;
#(
  parameter int         ERR_W  = 8,
  parameter logic [3:0] EXPECT = EXP_AND
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             vec_stb,
  input  logic [3:0]       vec_in,
  output logic             vec_valid,
  output logic [3:0]       truth_vec,
  output logic             mismatch,
  output logic [ERR_W-1:0] err_cnt
);

  logic miss;

  assign miss = vec_stb && (vec_in != EXPECT);

  // capture vector, one-cycle pulses, saturating errors
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec_valid <= 1'b0;
      truth_vec <= '0;
      mismatch  <= 1'b0;
      err_cnt   <= '0;
    end else begin
      vec_valid <= vec_stb;
      mismatch  <= miss;
      if (vec_stb)
        truth_vec <= vec_in;
      if (miss && (err_cnt != '1))
        err_cnt <= err_cnt + ERR_W'(1);
    end
  end

endmodule

// File: rtl/xy_stimulus_seq.sv
// xy_stimulus_seq: walks x/y through all four combos,
// samples z per combo and hands pass vectors to the checker.
module xy_stimulus_seq
  import xy_seq_pkg::*;
#(
  parameter int         ID_NUM      = 1,
  parameter int         HOLD_CYCLES = 2,
  parameter int         NUM_PASSES  = 3,
  parameter int         PASS_W      = 4,
  parameter logic [3:0] EXPECT      = EXP_AND,
  parameter int         ERR_W       = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic              z_in,
  output logic              x,
  output logic              y,
  output logic              busy,
  output logic              done,
  output logic              vec_valid,
  output logic [3:0]        truth_vec,
  output logic              mismatch,
  output logic [PASS_W-1:0] pass_cnt,
  output logic [ERR_W-1:0]  err_cnt,
  output logic [7:0]        id_out
);

  localparam logic [7:0] HOLD_LAST =
    8'(HOLD_CYCLES - 1);
  localparam logic [PASS_W-1:0] PASS_LAST =
    PASS_W'(NUM_PASSES);

  state_t             state, state_n;
  logic [COMBO_W-1:0] combo, combo_n;
  logic [7:0]         hold, hold_n;
  logic [2:0]         work, work_n;
  logic [PASS_W-1:0]  pass_n, pass_inc;
  logic               hold_end;
  logic               pass_end;
  logic [3:0]         full_vec;

  assign hold_end = (hold == HOLD_LAST);
  assign pass_inc = pass_cnt + PASS_W'(1);
  assign full_vec = {z_in, work};

  assign x      = (state == DRIVE) && combo[1];
  assign y      = (state == DRIVE) && combo[0];
  assign busy   = (state == DRIVE);
  assign done   = (state == DONE);
  assign id_out = 8'(ID_NUM);

  // state and counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      combo    <= '0;
      hold     <= '0;
      work     <= '0;
      pass_cnt <= '0;
    end else begin
      state    <= state_n;
      combo    <= combo_n;
      hold     <= hold_n;
      work     <= work_n;
      pass_cnt <= pass_n;
    end
  end

  // next state; abort wins over a pass end
  always_comb begin
    state_n  = state;
    combo_n  = combo;
    hold_n   = hold;
    work_n   = work;
    pass_n   = pass_cnt;
    pass_end = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_n = DRIVE;
          combo_n = '0;
          hold_n  = '0;
          work_n  = '0;
          pass_n  = '0;
        end
      end
      DRIVE: begin
        if (abort) begin
          state_n = IDLE;
          combo_n = '0;
          hold_n  = '0;
          work_n  = '0;
        end else if (hold_end) begin
          hold_n  = '0;
          combo_n = combo + COMBO_W'(1);
          unique case (combo)
            2'd0: work_n[0] = z_in;
            2'd1: work_n[1] = z_in;
            2'd2: work_n[2] = z_in;
            default: begin
              pass_end = 1'b1;
              work_n   = '0;
              pass_n   = pass_inc;
              if (pass_inc == PASS_LAST)
                state_n = DONE;
            end
          endcase
        end else begin
          hold_n = hold + 8'd1;
        end
      end
      DONE: begin
        state_n = IDLE;
        combo_n = '0;
        hold_n  = '0;
      end
      default: state_n = IDLE;
    endcase
  end

  xy_result_chk #(
    .ERR_W  (ERR_W),
    .EXPECT (EXPECT)
  ) u_chk (
    .clk       (clk),
    .rst_n     (rst_n),
    .vec_stb   (pass_end),
    .vec_in    (full_vec),
    .vec_valid (vec_valid),
    .truth_vec (truth_vec),
    .mismatch  (mismatch),
    .err_cnt   (err_cnt)
  );

endmodule

// File: tb/tb_xy_stimulus_seq.sv
// tb_xy_stimulus_seq: directed checks of the x/y sequencer
// with a behavioural z model in place of the instance.
module tb_xy_stimulus_seq;

  logic       clk;
  logic       rst_n;
  logic       start, abort, z_in, or_mode;
  logic       x, y, busy, done, vec_valid, mismatch;
  logic [3:0] truth_vec, pass_cnt;
  logic [7:0] err_cnt, id_out;

  logic       s_start, s_abort, s_z;
  logic       s_x, s_y, s_busy, s_done, s_vv, s_mis;
  logic [3:0] s_vec, s_pass;
  logic [1:0] s_err;
  logic [7:0] s_id;

  int n_run;
  int n_fail;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign z_in = or_mode ? (x | y) : (x & y);
  assign s_z  = s_x | s_y;

  xy_stimulus_seq #(
    .ID_NUM      (5),
    .HOLD_CYCLES (2),
    .NUM_PASSES  (3),
    .PASS_W      (4),
    .EXPECT      (4'b1000),
    .ERR_W       (8)
  ) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .z_in      (z_in),
    .x         (x),
    .y         (y),
    .busy      (busy),
    .done      (done),
    .vec_valid (vec_valid),
    .truth_vec (truth_vec),
    .mismatch  (mismatch),
    .pass_cnt  (pass_cnt),
    .err_cnt   (err_cnt),
    .id_out    (id_out)
  );

  xy_stimulus_seq #(
    .ID_NUM      (1),
    .HOLD_CYCLES (2),
    .NUM_PASSES  (5),
    .PASS_W      (4),
    .EXPECT      (4'b1000),
    .ERR_W       (2)
  ) u_sat (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (s_start),
    .abort     (s_abort),
    .z_in      (s_z),
    .x         (s_x),
    .y         (s_y),
    .busy      (s_busy),
    .done      (s_done),
    .vec_valid (s_vv),
    .truth_vec (s_vec),
    .mismatch  (s_mis),
    .pass_cnt  (s_pass),
    .err_cnt   (s_err),
    .id_out    (s_id)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  // start a 3-pass run and watch it cycle by cycle
  task automatic run_full(input logic [3:0] exp_vec,
                          input logic       exp_mis,
                          input logic       poke);
    int vv;
    int mm;
    int dn;
    logic [1:0] cmb;
    vv = 0;
    mm = 0;
    dn = 0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int k = 1; k <= 27; k++) begin
      @(negedge clk);
      start = poke && (k == 10 || k == 25);
      if (k <= 24) begin
        cmb = 2'((k - 1) / 2);
        chk("xy_seq", {30'd0, x, y}, {30'd0, cmb});
        if (k == 5 || k == 20)
          chk("busy_run", 32'(busy), 32'd1);
      end
      if (vec_valid) begin
        vv++;
        chk("vv_cycle", k, 8 * vv + 1);
        chk("truth_vec", 32'(truth_vec), 32'(exp_vec));
        chk("mis_flag", 32'(mismatch), 32'(exp_mis));
      end
      if (mismatch)
        mm++;
      if (done && dn == 0)
        dn = k;
    end
    start = 1'b0;
    chk("vv_count", vv, 3);
    chk("mis_count", mm, exp_mis ? 3 : 0);
    chk("done_cycle", dn, 25);
    chk("pass_cnt", 32'(pass_cnt), 32'd3);
    chk("busy_end", 32'(busy), 32'd0);
  endtask

  initial begin
    int dn;
    int bad;
    n_run   = 0;
    n_fail  = 0;
    start   = 1'b1;
    abort   = 1'b0;
    or_mode = 1'b0;
    s_start = 1'b0;
    s_abort = 1'b0;
    rst_n   = 1'b1;
    #3 rst_n = 1'b0;

    // reset with start held high
    repeat (3) @(negedge clk);
    chk("rst_xy", {30'd0, x, y}, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_pulses",
        {29'd0, done, vec_valid, mismatch}, 32'd0);
    chk("rst_vec", 32'(truth_vec), 32'd0);
    chk("rst_pass", 32'(pass_cnt), 32'd0);
    chk("rst_err", 32'(err_cnt), 32'd0);
    chk("rst_id", 32'(id_out), 32'd5);
    chk("rst_sat_id", 32'(s_id), 32'd1);
    start = 1'b0;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_busy", 32'(busy), 32'd0);

    // AND model, starts poked mid-run and in DONE
    run_full(4'b1000, 1'b0, 1'b1);
    chk("and_err", 32'(err_cnt), 32'd0);

    // OR model mismatches every pass
    or_mode = 1'b1;
    run_full(4'b1110, 1'b1, 1'b0);
    chk("or_err", 32'(err_cnt), 32'd3);
    or_mode = 1'b0;

    // abort in cycle 10
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (9) @(negedge clk);
    abort = 1'b1;
    chk("abort_busy_pre", 32'(busy), 32'd1);
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_xy", {30'd0, x, y}, 32'd0);
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (done || vec_valid || busy)
        bad++;
    end
    chk("abort_quiet", bad, 0);
    chk("abort_vec", 32'(truth_vec), 32'h8);
    chk("abort_pass", 32'(pass_cnt), 32'd1);
    chk("abort_err", 32'(err_cnt), 32'd3);

    // saturation on a 2-bit error counter
    @(negedge clk);
    s_start = 1'b1;
    @(posedge clk);
    #1 s_start = 1'b0;
    dn = 0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (s_done) begin
        dn = k;
        break;
      end
    end
    chk("sat_done_cycle", dn, 41);
    chk("sat_err", 32'(s_err), 32'd3);
    chk("sat_pass", 32'(s_pass), 32'd5);
    chk("sat_vec", 32'(s_vec), 32'he);

    // asynchronous reset mid-run
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(negedge clk);
    chk("mid_busy_pre", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_err", 32'(err_cnt), 32'd0);
    chk("mid_rst_vec", 32'(truth_vec), 32'd0);
    chk("mid_rst_pass", 32'(pass_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("mid_rst_idle", 32'(busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed",
             n_run, n_fail);
    $finish;
  end

endmodule
